s_round_arb: RTL and testbench
==============================

// Module: s_round_arb
// PURPOSE
//   Round-robin arbiter for N requesters sharing one resource; one registered one-hot grant per cycle.
//   Priority rotates so the requester just granted becomes lowest priority next cycle.
//   Sits between request sources and a shared bus or port.
//   Grant is combinationally independent of the current req; no combinational req->gnt path.
// PARAMETERS
//   N      4   number of requesters (>=2); req/gnt width
//   PTR_W  $clog2(N)   width of the internal priority pointer (derived, not overridden)
// PORTS
//   clk    input   1   single clock; all state updates on rising edge
//   rstn   input   1   reset, asynchronous, active-low
//   req    input   N   request vector; bit i high = requester i wants the resource this cycle
//   gnt    output  N   registered one-hot grant (or all-zero); bit i = requester i owns resource
// BEHAVIOUR
//   - Reset (rstn=0, async): gnt=0, ptr=0 (requester 0 highest priority). Held while rstn low.
//   - Every rising clk with rstn=1: sample req; compute grant from req and ptr; register into gnt.
//   - Latency: gnt reflects req sampled at the previous rising edge (1 cycle).
//   - Selection: search upward from index ptr, wrapping N-1 -> 0; first set req bit wins.
//   - Pointer update: if bit k granted, ptr <= (k+1) mod N; wrap from N-1 to 0.
//   - req==0: gnt <= 0, ptr unchanged.
//   - Non-preemptive hold not supported: a continuously asserted requester is re-arbitrated
//     every cycle and yields to any other pending requester.
//   - Fairness: with all N requesting, grants cycle 0,1,..,N-1,0,... (one each per N cycles).
//   - Single requester: granted every cycle while asserted.
//   - gnt always one-hot or zero; never more than one bit set.
//   - A requester dropping req loses gnt on the next edge; gnt never asserted for a bit
//     whose req was low at the sampling edge.
//   - Reset mid-operation: gnt clears immediately (async); ptr returns to 0.
//   - X on req is not filtered; the caller must drive req to known values after reset.
// STRUCTURE
//   - Shared package arb_pkg: default N, helper function for mod-N increment of ptr.
//   - Sub-module fixed_prio_arb #(N): combinational, lowest-index-wins one-hot encoder
//     (req -> gnt, plus any-grant flag).
//   - Top: two instances of fixed_prio_arb.
//     - Masked: req & (bits >= ptr).
//     - Unmasked: raw req.
//     - Masked result is used if non-zero, else unmasked.
//     - Binary index of the winner drives the ptr update.
//   - State: ptr register (PTR_W bits), gnt register (N bits).
// TESTING
//   - Reset: rstn=0 with req=4'b1111 -> gnt=0000 immediately and while held; release -> arbitration starts.
//   - After reset, req=4'b1101 held -> gnt sequence 0001, 0100, 1000, 0001, 0100 on successive edges.
//   - req=4'b1111 held -> 0001, 0010, 0100, 1000, 0001; each bit once per 4 cycles.
//   - Sweep req=1..15, one per cycle -> gnt always one-hot, subset of previous-cycle req,
//     chosen per ptr rule (reference model in bench); req=0 -> gnt=0, ptr unchanged.
//   - Single requester req=4'b0100 held -> gnt=0100 every cycle; then req=0 -> gnt=0000 next edge.
//   - Async reset asserted mid-sequence (between edges) -> gnt=0000 before next edge;
//     after release with req=4'b1111 -> first grant 0001.

Source files
------------

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the round-robin arbiter slice.
//   - ARB_N_DEF : default requester count
//   - ptr_inc() : mod-n increment used to rotate the priority pointer
// ----------------------------------------------------------------------------
package arb_pkg;

   localparam int unsigned ARB_N_DEF = 4;

   // Next pointer after granting index p, wrapping n-1 -> 0.
   function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
      return (p >= n - 1) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/fixed_prio_arb.sv
// ----------------------------------------------------------------------------
// fixed_prio_arb
//   Combinational fixed-priority arbiter: the lowest set bit of req wins.
//   Ports:
//     req  in  [N-1:0]  request vector
//     gnt  out [N-1:0]  one-hot winner, or zero when req is zero
//     any  out          at least one request present
// ----------------------------------------------------------------------------
module fixed_prio_arb #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         any
);

   // found[i] = some bit below i is already set; bit i wins only if none is.
   logic [N:0] found;

   assign found[0] = 1'b0;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign gnt[i]     = req[i] & ~found[i];
      assign found[i+1] = found[i] | req[i];
   end

   assign any = found[N];

endmodule

// File: rtl/s_round_arb.sv
// ----------------------------------------------------------------------------
// s_round_arb
//   Round-robin arbiter for N requesters with a registered one-hot grant.
//   The requester just granted becomes lowest priority on the next cycle.
//   gnt depends only on req/ptr sampled at the previous edge, so there is
//   no combinational req -> gnt path.
//   Ports:
//     clk   in           rising-edge clock
//     rstn  in           asynchronous active-low reset
//     req   in  [N-1:0]  request vector
//     gnt   out [N-1:0]  registered grant, one-hot or zero
// ----------------------------------------------------------------------------
module s_round_arb
   import arb_pkg::*;
#(
   parameter int unsigned N     = ARB_N_DEF,
   parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [N-1:0]     mask;
   logic [N-1:0]     req_m;
   logic [N-1:0]     gnt_m;
   logic [N-1:0]     gnt_u;
   logic [N-1:0]     gnt_sel;
   logic             any_m;
   logic             any_u;
   logic [PTR_W-1:0] win_idx;

   // Thermometer mask of bits at or above ptr: searching the masked vector
   // first, then the raw one, gives an upward search from ptr with wrap.
   for (genvar i = 0; i < N; i++) begin : g_mask
      assign mask[i] = (PTR_W'(i) >= ptr);
   end

   assign req_m = req & mask;

   fixed_prio_arb #(.N(N)) u_arb_masked (
      .req (req_m),
      .gnt (gnt_m),
      .any (any_m)
   );

   fixed_prio_arb #(.N(N)) u_arb_raw (
      .req (req),
      .gnt (gnt_u),
      .any (any_u)
   );

   assign gnt_sel = any_m ? gnt_m : gnt_u;

   // One-hot to binary; gnt_sel has at most one bit set.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_sel[i]) win_idx = PTR_W'(i);
      end
   end

   assign ptr_nxt = PTR_W'(ptr_inc(32'(win_idx), N));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt <= '0;
         ptr <= '0;
      end else begin
         gnt <= gnt_sel;
         // No request: hold priority where it is.
         if (any_u) ptr <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_s_round_arb.sv
module tb_s_round_arb;

   localparam int N = 4;

   logic         clk;
   logic         rstn;
   logic [N-1:0] req;
   logic [N-1:0] gnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [N-1:0] exp_q[$];
   int           mptr;       // reference model priority index
   logic [N-1:0] last_req;

   s_round_arb #(.N(N)) dut (
      .clk  (clk),
      .rstn (rstn),
      .req  (req),
      .gnt  (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: scan upward from mptr with wrap; first requester wins.
   task automatic model_step(input logic [N-1:0] r, output logic [N-1:0] g);
      int win;
      g   = '0;
      win = -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (mptr + k) % N;
         if (win < 0 && r[j]) win = j;
      end
      if (win >= 0) begin
         g[win] = 1'b1;
         mptr   = (win + 1) % N;
      end
   endtask

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: gnt=%b expected=%b t=%0t", name, act, want, $time);
      end
   endtask

   // Drive req for one edge; expectation from the model.
   task automatic drive(input logic [N-1:0] r);
      logic [N-1:0] g;
      @(negedge clk);
      req = r;
      model_step(r, g);
      last_req = r;
      exp_q.push_back(g);
   endtask

   // Drive req for one edge with a fixed expected grant; model kept in step.
   task automatic directed(input logic [N-1:0] r, input logic [N-1:0] want);
      logic [N-1:0] g;
      @(negedge clk);
      req = r;
      model_step(r, g);
      last_req = r;
      exp_q.push_back(want);
   endtask

   // Assert reset between edges, verify gnt clears at once and stays clear,
   // then release together with an idle cycle.
   task automatic do_reset(input string name);
      logic [N-1:0] g;
      @(posedge clk);
      #2;
      rstn = 1'b0;
      req  = 4'b1111;
      #1;
      check({name, "_async"}, gnt, 4'b0000);
      repeat (3) begin
         @(negedge clk);
         check({name, "_held"}, gnt, 4'b0000);
      end
      @(negedge clk);
      rstn = 1'b1;
      req  = '0;
      mptr = 0;
      model_step('0, g);
      exp_q.push_back(g);
   endtask

   // Monitor: one expectation per active edge, sampled after the edge.
   always @(posedge clk) begin
      logic [N-1:0] e;
      #1;
      if (rstn && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gnt", gnt, e);
         n_cmp++;
         if (!$onehot0(gnt)) begin
            n_err++;
            $display("FAIL onehot: gnt=%b expected at most one bit", gnt);
         end
      end
   end

   initial begin
      rstn     = 1'b0;
      req      = 4'b1111;
      mptr     = 0;
      last_req = '0;
      #1;
      check("reset_init", gnt, 4'b0000);
      repeat (2) begin
         @(negedge clk);
         check("reset_init_held", gnt, 4'b0000);
      end
      @(negedge clk);
      rstn = 1'b1;
      req  = '0;
      exp_q.push_back(4'b0000);

      // 1101 held
      directed(4'b1101, 4'b0001);
      directed(4'b1101, 4'b0100);
      directed(4'b1101, 4'b1000);
      directed(4'b1101, 4'b0001);
      directed(4'b1101, 4'b0100);

      // all requesting: strict rotation
      do_reset("rst_a");
      for (int i = 0; i < 8; i++) directed(4'b1111, 4'(1 << (i % 4)));

      // sweep every non-zero pattern, then zero
      for (int r = 1; r < 16; r++) drive(4'(r));
      drive(4'b0000);
      drive(4'b0000);

      // single requester, then drop
      for (int i = 0; i < 4; i++) directed(4'b0100, 4'b0100);
      directed(4'b0000, 4'b0000);

      // random traffic
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0) drive('0);
         else drive(4'($urandom_range(0, 15)));
      end

      // mid-sequence reset, then full contention restarts at requester 0
      drive(4'b1111);
      drive(4'b1111);
      do_reset("rst_mid");
      directed(4'b1111, 4'b0001);
      directed(4'b1111, 4'b0010);
      for (int i = 0; i < 50; i++) drive(4'($urandom_range(0, 15)));

      // drain with a bound
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: pending=%0d expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
